// File: rtl/line_window_gen_pkg.sv
// Shared types for the line window generator.
// Border modes and the column-index width helper.
package line_buf_pkg;

  typedef enum logic [1:0] {
    BORDER_SKIP = 2'd0,
    BORDER_ZERO = 2'd1,
    BORDER_REPL = 2'd2
  } border_mode_e;

  function automatic int col_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One stored image row: single address, write enable,
// asynchronous read so the old word is seen during a write.
module line_ram
  import line_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  localparam int AW        = col_w(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/line_window_gen.sv
// Vertical pixel column generator over NUM_LINES rows with
// stream handshake, line/frame markers and top-border handling.
module line_window_gen
  import line_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 640,
  parameter int NUM_LINES  = 3,
  localparam int WW        = $clog2(MAX_WIDTH + 1),
  localparam int CW        = col_w(MAX_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WW-1:0]         cfg_width,
  input  logic [1:0]            cfg_border,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data [NUM_LINES],
  output logic                  m_sof,
  output logic                  m_eol,
  output logic [CW-1:0]         m_col,
  output logic                  len_err
);

  localparam int NS = NUM_LINES - 1;
  localparam int RW = col_w(NUM_LINES);

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_rows;
  logic [WW-1:0]         r_width;
  border_mode_e          r_mode;

  logic [CW-1:0]         w_col;
  logic [RW-1:0]         w_rows;
  logic [WW-1:0]         w_width;
  border_mode_e          w_mode;
  logic                  w_acc;
  logic                  w_last;
  logic                  w_end;
  logic                  w_emit;

  logic [DATA_WIDTH-1:0] w_rd   [NS];
  logic [DATA_WIDTH-1:0] w_row  [NUM_LINES];
  logic [DATA_WIDTH-1:0] w_tap  [NUM_LINES];
  logic [DATA_WIDTH-1:0] w_edge;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data [NUM_LINES];
  logic                  r_sof;
  logic                  r_eol;
  logic [CW-1:0]         r_mcol;
  logic                  r_len_err;

  assign s_ready = !r_valid || m_ready;
  assign w_acc   = s_valid && s_ready && !rst;

  // An SOF beat uses fresh config and a cleared position.
  always_comb begin
    w_col   = s_sof ? '0 : r_col;
    w_rows  = s_sof ? '0 : r_rows;
    w_width = s_sof ? cfg_width : r_width;
    w_mode  = r_mode;
    if (s_sof) begin
      case (cfg_border)
        2'd0:    w_mode = BORDER_SKIP;
        2'd2:    w_mode = BORDER_REPL;
        default: w_mode = BORDER_ZERO;
      endcase
    end
    w_last = (WW'(w_col) == w_width - WW'(1))
          || (w_col == CW'(MAX_WIDTH - 1));
    w_end  = s_eol || w_last;
    w_emit = (w_mode != BORDER_SKIP)
          || (w_rows == RW'(NS));
  end

  always_comb begin
    w_row[0] = s_data;
    for (int k = 1; k < NUM_LINES; k++) begin
      w_row[k] = w_rd[k-1];
    end
  end

  assign w_edge = w_row[w_rows];

  always_comb begin
    for (int k = 0; k < NUM_LINES; k++) begin
      w_tap[k] = w_row[k];
      if (k > int'(w_rows)) begin
        unique case (1'b1)
          w_mode == BORDER_REPL: w_tap[k] = w_edge;
          w_mode == BORDER_ZERO: w_tap[k] = '0;
          default: ;
        endcase
      end
    end
  end

  // Each row store shifts its old word into the next one.
  for (genvar g = 0; g < NS; g++) begin : g_row
    logic [DATA_WIDTH-1:0] w_wdata;
    if (g == 0) begin : g_first
      assign w_wdata = s_data;
    end else begin : g_next
      assign w_wdata = w_rd[g-1];
    end
    line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_WIDTH)
    ) u_ram (
      .i_clk   (clk),
      .i_we    (w_acc),
      .i_addr  (w_col),
      .i_wdata (w_wdata),
      .o_rdata (w_rd[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_rows  <= '0;
      r_width <= '0;
      r_mode  <= BORDER_ZERO;
    end else if (w_acc) begin
      r_col <= w_end ? '0 : w_col + CW'(1);
      if (w_end && (w_rows != RW'(NS))) begin
        r_rows <= w_rows + RW'(1);
      end else begin
        r_rows <= w_rows;
      end
      if (s_sof) begin
        r_width <= cfg_width;
        r_mode  <= w_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_data    <= '{default: '0};
      r_sof     <= 1'b0;
      r_eol     <= 1'b0;
      r_mcol    <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_acc && (s_eol != w_last);
      if (w_acc) begin
        r_valid <= w_emit;
        r_data  <= w_tap;
        r_sof   <= s_sof;
        r_eol   <= w_end;
        r_mcol  <= w_col;
      end else if (m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_sof   = r_sof;
  assign m_eol   = r_eol;
  assign m_col   = r_mcol;
  assign len_err = r_len_err;

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench for line_window_gen: per-column history
// model, random ready/gaps, directed border and length cases.
module tb_line_window_gen;

  localparam int DW = 8;
  localparam int MW = 8;
  localparam int NL = 3;

  logic          clk;
  logic          rst;
  logic [3:0]    cfg_width;
  logic [1:0]    cfg_border;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_sof;
  logic          s_eol;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data [NL];
  logic          m_sof;
  logic          m_eol;
  logic [2:0]    m_col;
  logic          len_err;

  line_window_gen #(
    .DATA_WIDTH (DW),
    .MAX_WIDTH  (MW),
    .NUM_LINES  (NL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_width  (cfg_width),
    .cfg_border (cfg_border),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .s_eol      (s_eol),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_col      (m_col),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NL-1:0][DW-1:0] d;
    logic                  sof;
    logic                  eol;
    logic [2:0]            col;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: frame position and per-column write history
  int       mc, mrows, mwidth, mmode;
  logic [DW-1:0] hist [MW][2];

  bit in_rst = 1'b1;
  bit acc_now, emit_now, err_now;
  int rdy_mode = 0;
  bit tog = 1'b0;
  bit gap_en = 1'b0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic bit next_ready();
    case (rdy_mode)
      1: begin tog = !tog; return tog; end
      2: return $urandom_range(0, 3) != 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_beat(input logic [DW-1:0] d,
                            input bit sof, input bit eol);
    exp_t e;
    int c;
    bit last, fin;
    logic [DW-1:0] rv [NL];
    if (sof) begin
      mc = 0; mrows = 0;
      mwidth = int'(cfg_width);
      mmode = int'(cfg_border);
    end
    c = mc;
    last = (c == mwidth - 1);
    fin = eol || last;
    rv[0] = d;
    rv[1] = hist[c][0];
    rv[2] = hist[c][1];
    for (int k = 0; k < NL; k++) begin
      if (k <= mrows) e.d[k] = rv[k];
      else if (mmode == 2) e.d[k] = rv[mrows];
      else e.d[k] = '0;
    end
    e.sof = sof;
    e.eol = fin;
    e.col = 3'(c);
    acc_now = 1'b1;
    err_now = (eol != last);
    emit_now = (mmode != 0) || (mrows == NL - 1);
    if (emit_now) q.push_back(e);
    hist[c][1] = hist[c][0];
    hist[c][0] = d;
    mc = fin ? 0 : c + 1;
    if (fin && mrows < NL - 1) mrows++;
  endtask

  task automatic idle();
    @(negedge clk);
    m_ready = next_ready();
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_eol = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d,
                      input bit sof, input bit eol);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    if (gap_en && $urandom_range(0, 3) == 0) idle();
    while (!acc && n < 64) begin
      @(negedge clk);
      m_ready = next_ready();
      s_valid = 1'b1;
      s_data = d;
      s_sof = sof;
      s_eol = eol;
      #1;
      acc = s_ready && !rst;
      if (acc) model_beat(d, sof, eol);
      n++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: beat %0h not taken", d);
    end
  endtask

  task automatic send_row(input int r, input int n,
                          input bit with_eol, input bit sof0,
                          input bit rnd);
    logic [DW-1:0] d;
    for (int c = 0; c < n; c++) begin
      d = rnd ? DW'($urandom) : DW'(16 * r + c);
      send(d, sof0 && c == 0, with_eol && c == n - 1);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    in_rst = 1'b1;
    rst = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h5a;
    s_sof = 1'b0;
    s_eol = 1'b0;
    q.delete();
    mc = 0; mrows = 0; mwidth = 0; mmode = 1;
    @(negedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    for (int k = 0; k < NL; k++)
      chk("rst_m_data", 32'(m_data[k]), 0);
    chk("rst_m_sof", 32'(m_sof), 0);
    chk("rst_m_eol", 32'(m_eol), 0);
    chk("rst_m_col", 32'(m_col), 0);
    chk("rst_len_err", 32'(len_err), 0);
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid2", 32'(m_valid), 0);
    acc_now = 0; emit_now = 0; err_now = 0;
    in_rst = 1'b0;
  endtask

  // monitor: pops the scoreboard on each transfer
  initial begin : monitor
    bit acc_p, emit_p, err_p, held;
    exp_t h, e;
    acc_p = 0; emit_p = 0; err_p = 0; held = 0;
    forever begin
      @(negedge clk);
      #2;
      if (in_rst) begin
        acc_p = 0; emit_p = 0; err_p = 0; held = 0;
        acc_now = 0; emit_now = 0; err_now = 0;
      end else begin
        chk("s_ready", 32'(s_ready),
            32'(!(m_valid && !m_ready)));
        chk("len_err", 32'(len_err), 32'(err_p));
        if (acc_p) chk("latency", 32'(m_valid), 32'(emit_p));
        if (held) begin
          chk("stall_valid", 32'(m_valid), 1);
          for (int k = 0; k < NL; k++)
            chk("stall_data", 32'(m_data[k]), 32'(h.d[k]));
          chk("stall_sof", 32'(m_sof), 32'(h.sof));
          chk("stall_eol", 32'(m_eol), 32'(h.eol));
          chk("stall_col", 32'(m_col), 32'(h.col));
        end
        if (m_valid && m_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", 32'(q.size()), 1);
          end else begin
            e = q.pop_front();
            for (int k = 0; k < NL; k++)
              chk("m_data", 32'(m_data[k]), 32'(e.d[k]));
            chk("m_sof", 32'(m_sof), 32'(e.sof));
            chk("m_eol", 32'(m_eol), 32'(e.eol));
            chk("m_col", 32'(m_col), 32'(e.col));
          end
        end
        held = m_valid && !m_ready;
        for (int k = 0; k < NL; k++) h.d[k] = m_data[k];
        h.sof = m_sof;
        h.eol = m_eol;
        h.col = m_col;
        acc_p = acc_now; emit_p = emit_now; err_p = err_now;
        acc_now = 0; emit_now = 0; err_now = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w, nr, n;
    bit eo;
    rst = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_sof = 1'b0;
    s_eol = 1'b0;
    cfg_width = 4'd4;
    cfg_border = 2'd1;
    for (int c = 0; c < MW; c++) begin
      hist[c][0] = '0;
      hist[c][1] = '0;
    end
    reset_dut();

    // fill every column so all history is defined
    cfg_width = 4'd8; cfg_border = 2'd1;
    for (int r = 0; r < 3; r++) send_row(r, 8, 1, r == 0, 1);

    cfg_width = 4'd4;
    for (int m = 1; m >= 0; m = (m == 1) ? 2 : (m == 2 ? 0 : -1)) begin
      cfg_border = 2'(m);
      for (int r = 0; r < 3; r++) send_row(r, 4, 1, r == 0, 0);
    end

    // backpressure toggling during row 2
    cfg_border = 2'd1;
    send_row(0, 4, 1, 1, 0);
    send_row(1, 4, 1, 0, 0);
    rdy_mode = 1;
    send_row(2, 4, 1, 0, 0);
    rdy_mode = 0;

    // early EOL, missing EOL
    send_row(0, 4, 1, 1, 0);
    send_row(1, 3, 1, 0, 0);
    send_row(2, 4, 0, 0, 0);
    send_row(3, 4, 1, 0, 0);

    // SOF in the middle of row 2
    for (int m = 1; m <= 2; m++) begin
      cfg_border = 2'(m);
      send_row(0, 4, 1, 1, 0);
      send_row(1, 4, 1, 0, 0);
      send(8'h20, 0, 0);
      send(8'h21, 0, 0);
      send(8'h22, 1, 0);
      send(8'h23, 0, 0);
      send(8'h24, 0, 0);
      send(8'h25, 0, 1);
      send_row(1, 4, 1, 0, 0);
    end

    // reset mid-frame
    cfg_border = 2'd2;
    send_row(0, 4, 1, 1, 0);
    send(8'h10, 0, 0);
    send(8'h11, 0, 0);
    reset_dut();

    // random frames
    gap_en = 1'b1;
    for (int f = 0; f < 24; f++) begin
      w = $urandom_range(1, MW);
      cfg_width = 4'(w);
      cfg_border = 2'($urandom_range(0, 2));
      rdy_mode = $urandom_range(0, 2);
      nr = $urandom_range(2, 5);
      for (int r = 0; r < nr; r++) begin
        n = w;
        eo = 1'b1;
        case ($urandom_range(0, 7))
          0: n = $urandom_range(1, w);
          1: eo = 1'b0;
          default: ;
        endcase
        send_row(r, n, eo, r == 0, 1);
      end
    end
    gap_en = 1'b0;

    rdy_mode = 0;
    repeat (6) idle();
    chk("drain_empty", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
